// File: rtl/exception_ctrl.sv
// MEM-stage exception detector and sequencer feeding cp0, the flush network and the fetch redirect.
// Optional exception counter: define EXC_STATS_EN to add exc_count_o.
//
// state    | meaning
// IDLE     | watching MEM for a valid instruction with a flag or pending interrupt
// COMMIT   | one-cycle cp0 write window, first flush cycle
// FLUSH    | remaining flush cycles, counted down to terminal count
// REDIRECT | redirect PC offered to fetch until pc_ack_i
module exception_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'hBFC0_0380,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic [7:0]  mem_exc_flags_i,
  input  logic [31:0] mem_bad_addr_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        pc_ack_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] except_pc_o,
  output logic        except_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] newpc_o,
  output logic        newpc_valid_o,
  output logic        busy_o
`ifdef EXC_STATS_EN
  ,
  output logic [31:0] exc_count_o
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMMIT   = 2'd1,
    FLUSH    = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam bit         SKIP_FLUSH = (FLUSH_CYCLES <= 1);

  localparam logic [4:0] CODE_INT  = 5'h01;
  localparam logic [4:0] CODE_ADEL = 5'h04;
  localparam logic [4:0] CODE_ADES = 5'h05;
  localparam logic [4:0] CODE_SYS  = 5'h08;
  localparam logic [4:0] CODE_BRK  = 5'h09;
  localparam logic [4:0] CODE_RI   = 5'h0a;
  localparam logic [4:0] CODE_OV   = 5'h0c;
  localparam logic [4:0] CODE_ERET = 5'h0e;

  state_t      state, state_n;
  logic [3:0]  flush_cnt;

  logic        irq_pending;
  logic        exc_hit;
  logic        detect;
  logic [4:0]  code_d;
  logic [31:0] bad_d;
  logic        eret_d;

  logic [4:0]  code_q;
  logic [31:0] pc_q;
  logic        ds_q;
  logic [31:0] bad_q;
  logic [31:0] newpc_q;

  // Only the interrupt mask and pending fields take part in the decision.
  logic unused_cp0_bits;
  assign unused_cp0_bits = ^{cp0_status_i[31:16], cp0_status_i[7:2],
                             cp0_cause_i[31:16], cp0_cause_i[7:0]};

  assign irq_pending = cp0_status_i[0] & ~cp0_status_i[1] &
                       (|(cp0_cause_i[15:8] & cp0_status_i[15:8]));

  // Priority pick; flags: {ades,adel_d,eret,brk,sys,ov,ri,adel_if}.
  always_comb begin
    code_d = 5'h00;
    bad_d  = 32'h0;
    eret_d = 1'b0;
    if (irq_pending) begin
      code_d = CODE_INT;
    end else if (mem_exc_flags_i[0]) begin
      code_d = CODE_ADEL;
      bad_d  = mem_pc_i;
    end else if (mem_exc_flags_i[1]) begin
      code_d = CODE_RI;
    end else if (mem_exc_flags_i[2]) begin
      code_d = CODE_OV;
    end else if (mem_exc_flags_i[3]) begin
      code_d = CODE_SYS;
    end else if (mem_exc_flags_i[4]) begin
      code_d = CODE_BRK;
    end else if (mem_exc_flags_i[6]) begin
      code_d = CODE_ADEL;
      bad_d  = mem_bad_addr_i;
    end else if (mem_exc_flags_i[7]) begin
      code_d = CODE_ADES;
      bad_d  = mem_bad_addr_i;
    end else if (mem_exc_flags_i[5]) begin
      code_d = CODE_ERET;
      eret_d = 1'b1;
    end
  end

  assign exc_hit = irq_pending | (|mem_exc_flags_i);
  assign detect  = (state == IDLE) & mem_valid_i & exc_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      code_q  <= 5'h00;
      pc_q    <= 32'h0;
      ds_q    <= 1'b0;
      bad_q   <= 32'h0;
      newpc_q <= 32'h0;
    end else if (detect) begin
      code_q  <= code_d;
      pc_q    <= mem_pc_i;
      ds_q    <= mem_in_delayslot_i;
      bad_q   <= bad_d;
      newpc_q <= eret_d ? cp0_epc_i : HANDLER_ADDR;
    end
  end

  // COMMIT is the first flush cycle, so the counter holds the cycles still owed.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt <= 4'd0;
    end else if (state == COMMIT) begin
      flush_cnt <= FLUSH_LOAD;
    end else if (state == FLUSH) begin
      flush_cnt <= flush_cnt - 4'd1;
    end
  end

  always_comb begin
    state_n            = state;
    excepttype_o       = 32'h0;
    except_pc_o        = 32'h0;
    except_delayslot_o = 1'b0;
    bad_addr_o         = 32'h0;
    flush_o            = 1'b0;
    newpc_o            = 32'h0;
    newpc_valid_o      = 1'b0;
    busy_o             = 1'b1;
    case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (detect) state_n = COMMIT;
      end
      COMMIT: begin
        excepttype_o       = {27'h0, code_q};
        except_pc_o        = pc_q;
        except_delayslot_o = ds_q;
        bad_addr_o         = bad_q;
        flush_o            = 1'b1;
        state_n            = SKIP_FLUSH ? REDIRECT : FLUSH;
      end
      FLUSH: begin
        flush_o = 1'b1;
        if (flush_cnt == 4'd1) state_n = REDIRECT;
      end
      REDIRECT: begin
        newpc_o       = newpc_q;
        newpc_valid_o = 1'b1;
        if (pc_ack_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef EXC_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      exc_count_o <= 32'h0;
    end else if (state == COMMIT) begin
      exc_count_o <= exc_count_o + 32'd1;
    end
  end
`endif

endmodule
